// File: rtl/maxnet_pkg.sv
// Shared constants, state encoding and the optional negative-clamp rule for the Maxnet activation loader.
// Optional feature macro: MAXNET_CLAMP_NEG_EN (store negative words as zero).
package maxnet_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NUM_PU = 4;
    localparam int unsigned CNT_W  = $clog2(NUM_PU);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        CHECK  = 2'd1,
        LAUNCH = 2'd2,
        WAIT   = 2'd3
    } state_e;

    // Value actually stored in a lane for an incoming word
    function automatic logic [DATA_W-1:0] clamp_word(input logic [DATA_W-1:0] word);
`ifdef MAXNET_CLAMP_NEG_EN
        return word[DATA_W-1] ? '0 : word;
`else
        return word;
`endif
    endfunction

endpackage

// File: rtl/maxnet_act_reg.sv
// One activation lane register: load enable, async clear, optional negative clamp.
// Optional feature macro: MAXNET_CLAMP_NEG_EN (applied through maxnet_pkg::clamp_word).
module maxnet_act_reg
    import maxnet_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= clamp_word(i_data);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/maxnet_act_loader.sv
// Buffers four serial activation words into lane registers and launches the Maxnet datapath.
// Optional feature macro: MAXNET_CLAMP_NEG_EN (negative words stored as zero).
module maxnet_act_loader
    import maxnet_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    input  logic              is_finished,
    output logic              start,
    output logic [DATA_W-1:0] a1,
    output logic [DATA_W-1:0] a2,
    output logic [DATA_W-1:0] a3,
    output logic [DATA_W-1:0] a4,
    output logic              busy,
    output logic              err_all_zero
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_in_ready;
    logic              w_in_ready_nxt;
    logic              r_start;
    logic              w_start_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_err;
    logic              w_err_nxt;

    logic              w_xfer;
    logic              w_lanes_zero;
    logic              w_frame_zero;
    logic [NUM_PU-1:0] w_load;
    logic [DATA_W-1:0] w_lane [NUM_PU];

    // A flushed beat is dropped, never written
    assign w_xfer = (r_state == FILL) && r_in_ready && in_valid && !flush;

    for (genvar k = 0; k < NUM_PU; k++) begin : g_lane
        assign w_load[k] = w_xfer && (r_cnt == CNT_W'(k));

        maxnet_act_reg u_lane (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_load  (w_load[k]),
            .i_data  (in_data),
            .o_q     (w_lane[k])
        );
    end

    always_comb begin
        w_lanes_zero = 1'b1;
        for (int unsigned k = 0; k < NUM_PU; k++) begin
            if (w_lane[k] != '0) w_lanes_zero = 1'b0;
        end
    end

    // Zero test of the frame as it will stand once the incoming last beat lands
    always_comb begin
        w_frame_zero = (clamp_word(in_data) == '0);
        for (int unsigned k = 0; k < NUM_PU - 1; k++) begin
            if (w_lane[k] != '0) w_frame_zero = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        case (r_state)
            FILL: begin
                if (flush) begin
                    w_cnt_nxt = '0;
                end else if (w_xfer) begin
                    if (r_cnt == CNT_W'(NUM_PU - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = CHECK;
                        w_err_nxt   = w_frame_zero;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            CHECK:   w_state_nxt = w_lanes_zero ? FILL : LAUNCH;
            LAUNCH:  w_state_nxt = WAIT;
            WAIT:    if (is_finished) w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
        w_in_ready_nxt = (w_state_nxt == FILL);
        w_start_nxt    = (w_state_nxt == LAUNCH);
        w_busy_nxt     = (w_state_nxt == LAUNCH) || (w_state_nxt == WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_in_ready <= w_in_ready_nxt;
            r_start    <= w_start_nxt;
            r_busy     <= w_busy_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign in_ready     = r_in_ready;
    assign start        = r_start;
    assign busy         = r_busy;
    assign err_all_zero = r_err;
    assign a1           = w_lane[0];
    assign a2           = w_lane[1];
    assign a3           = w_lane[2];
    assign a4           = w_lane[3];

endmodule

// File: tb/tb_maxnet_act_loader.sv
// Scoreboard bench for maxnet_act_loader: random frames, frame-level reference model, decoupled monitor.
// Honours MAXNET_CLAMP_NEG_EN in its reference model when the macro is defined.
module tb_maxnet_act_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        flush;
    logic        is_finished;
    logic        start;
    logic [31:0] a1, a2, a3, a4;
    logic        busy;
    logic        err_all_zero;

    maxnet_act_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .flush        (flush),
        .is_finished  (is_finished),
        .start        (start),
        .a1           (a1),
        .a2           (a2),
        .a3           (a3),
        .a4           (a4),
        .busy         (busy),
        .err_all_zero (err_all_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             is_err;
        logic [3:0][31:0] lanes;
        longint           due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] beats[$];
    longint      cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [3:0][31:0] launched = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Stored value of a word under the active build
    function automatic logic [31:0] mdl_store(input logic [31:0] w);
`ifdef MAXNET_CLAMP_NEG_EN
        return w[31] ? 32'd0 : w;
`else
        return w;
`endif
    endfunction

    // Reference model: called at the negedge before the edge that takes the beat
    task automatic model_beat(input logic [31:0] w);
        exp_t e;
        beats.push_back(mdl_store(w));
        if (beats.size() == 4) begin
            for (int i = 0; i < 4; i++) e.lanes[i] = beats[i];
            e.is_err = (e.lanes == '0);
            e.due    = e.is_err ? cyc + 1 : cyc + 2;
            exp_q.push_back(e);
            beats.delete();
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        forever begin
            if (in_ready) begin
                model_beat(w);
                @(negedge clk);
                break;
            end
            @(negedge clk);
            n++;
            if (n > 200) begin
                check_eq("in_ready timeout", 1'b0, 1'b1);
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    // Drive one frame and the datapath handshake that follows it
    task automatic send_frame(input logic [3:0][31:0] fr, input int gmin, input int gmax,
                              input bit early_fin, input int wait_cyc);
        logic is_err;
        for (int i = 0; i < 4; i++) begin
            send_word(fr[i]);
            if (i < 3) repeat ($urandom_range(gmin, gmax)) @(negedge clk);
        end
        is_err = (mdl_store(fr[0]) | mdl_store(fr[1]) | mdl_store(fr[2]) | mdl_store(fr[3])) == 32'd0;
        if (is_err) begin
            @(negedge clk);
            check_eq("ready after err", {busy, in_ready}, 2'b01);
        end else if (early_fin) begin
            is_finished = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check_eq("early fin wait", {busy, in_ready}, 2'b10);
            @(negedge clk);
            check_eq("early fin done", {busy, in_ready}, 2'b01);
            is_finished = 1'b0;
        end else begin
            @(negedge clk);
            @(negedge clk);
            repeat (wait_cyc) begin
                in_valid = 1'b1;
                in_data  = $urandom;
                check_eq("wait stall", {busy, in_ready}, 2'b10);
                @(negedge clk);
            end
            in_valid    = 1'b0;
            is_finished = 1'b1;
            @(negedge clk);
            check_eq("fin release", {busy, in_ready}, 2'b01);
            is_finished = 1'b0;
        end
    endtask

    task automatic do_flush(input int nb);
        for (int i = 0; i < nb; i++) send_word($urandom | 32'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = $urandom | 32'd1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        beats.delete();
    endtask

    function automatic logic [3:0][31:0] mk(input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [31:0] w2, input logic [31:0] w3);
        logic [3:0][31:0] f;
        f[0] = w0; f[1] = w1; f[2] = w2; f[3] = w3;
        return f;
    endfunction

    // Monitor: pop the scoreboard whenever the DUT reports an outcome
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                check_eq("missing event", {start, err_all_zero}, e.is_err ? 2'b01 : 2'b10);
            end
            if (start || err_all_zero) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected event", {start, err_all_zero}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("event kind", {start, err_all_zero}, e.is_err ? 2'b01 : 2'b10);
                    check_eq("event cycle", 128'(cyc), 128'(e.due));
                    if (!e.is_err) check_eq("lanes at start", {a4, a3, a2, a1}, e.lanes);
                end
            end
            if (start) launched = {a4, a3, a2, a1};
            if (busy) check_eq("lanes frozen", {a4, a3, a2, a1}, launched);
            if (busy && in_ready) check_eq("busy and ready", 1'b1, 1'b0);
            if (start && !busy) check_eq("start without busy", busy, 1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][31:0] fr;
        int sel;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        flush       = 1'b0;
        is_finished = 1'b0;
        #1;
        check_eq("reset outputs", {in_ready, start, busy, err_all_zero, a1, a2, a3, a4}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready after reset", in_ready, 1'b1);

        send_frame(mk(5, 9, 3, 7), 0, 0, 1'b0, 10);
        send_frame(mk(5, 9, 3, 7), 1, 1, 1'b0, 3);
        send_frame(mk(0, 0, 0, 0), 0, 0, 1'b0, 0);
        do_flush(2);
        send_frame(mk(1, 2, 3, 4), 0, 0, 1'b1, 0);

        // Asynchronous reset in the middle of a frame
        for (int i = 0; i < 3; i++) send_word(32'd11 + 32'(i));
        #2 rst_n = 1'b0;
        #1;
        check_eq("async reset outputs", {in_ready, start, busy, err_all_zero, a1, a2, a3, a4}, '0);
        beats.delete();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready after mid reset", in_ready, 1'b1);
        send_frame(mk(8, 0, 0, 0), 0, 0, 1'b0, 2);
        send_frame(mk(32'hFFFF_FFFF, 0, 0, 0), 0, 0, 1'b0, 1);

        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0:       fr[i] = 32'd0;
                    1:       fr[i] = 32'($urandom_range(1, 100));
                    2:       fr[i] = $urandom;
                    default: fr[i] = 32'h8000_0000 | $urandom;
                endcase
            end
            sel = $urandom_range(0, 9);
            if (sel == 0) fr = '0;
            if (sel == 1) do_flush($urandom_range(1, 3));
            send_frame(fr, 0, 2, 1'($urandom_range(0, 1)), $urandom_range(0, 10));
        end

        repeat (3) @(negedge clk);
        check_eq("scoreboard drained", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
